// File: rtl/sm83_reg_wz_bank.sv
// ---------------------------------------------------------------------------
// sm83_reg_wz_bank
//
// WIDTH-bit temporary register, the parametrised successor to the single-pair
// WZ output cell. The register can be loaded in two ways:
//   * as a whole word in one cycle, or
//   * byte-serially from the 8-bit data bus, low byte first, with a
//     valid/ready handshake.
// It can also be incremented with a registered carry-out. The contents are
// driven onto NBUS precharged, active-low pulldown buses, and an inverting
// 2:1 mux is provided.
//
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      synchronous, active-high reset
//   pch        precharge phase (1 = buses precharged high, 0 = evaluate)
//   din        data bus byte for the sequential loader
//   din_valid  din carries a loader byte this cycle
//   din_ready  loader accepts din this cycle
//   seq_start  begin a byte-serial load, low byte first
//   wide_ld    load wide_d into the whole register
//   wide_d     word for wide_ld
//   inc        increment the register by one
//   oe         per-bus drive enable
//   mux_sel    inverting mux select (1 = ~q, 0 = ~mux_alt)
//   mux_alt    alternate mux source
//   q          register contents
//   bus_y      bus b occupies bits [b*WIDTH +: WIDTH]
//   mux_y      inverting mux output (combinational)
//   busy       byte-serial load in progress
//   done       one-cycle pulse after the last byte has been written
//   carry      carry-out of the most recent accepted increment
//   err        one-cycle pulse on a dropped or overridden operation
// ---------------------------------------------------------------------------
module sm83_reg_wz_bank #(
    parameter int WIDTH = 16,
    parameter int NBUS  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pch,
    input  logic [7:0]             din,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic                   seq_start,
    input  logic                   wide_ld,
    input  logic [WIDTH-1:0]       wide_d,
    input  logic                   inc,
    input  logic [NBUS-1:0]        oe,
    input  logic                   mux_sel,
    input  logic [WIDTH-1:0]       mux_alt,
    output logic [WIDTH-1:0]       q,
    output logic [NBUS*WIDTH-1:0]  bus_y,
    output logic [WIDTH-1:0]       mux_y,
    output logic                   busy,
    output logic                   done,
    output logic                   carry,
    output logic                   err
);

    localparam int BYTES = WIDTH / 8;
    // Byte index width; at least one bit so a single-byte register still
    // has a legal index register.
    localparam int KW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [KW-1:0] LAST = KW'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEQ,
        DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] k;

    // Loader handshake is only offered while a sequence is running, and
    // never while reset is asserted.
    assign din_ready = (state == SEQ) && !reset;
    assign busy      = (state == SEQ);

    // Inverting mux, purely combinational.
    assign mux_y = mux_sel ? ~q : ~mux_alt;

    // Precharged pulldown buses: high during precharge; during evaluate a
    // bit is pulled low only where the register bit is 1 and that bus is
    // enabled.
    for (genvar b = 0; b < NBUS; b++) begin : g_bus
        assign bus_y[b*WIDTH +: WIDTH] = pch ? {WIDTH{1'b1}}
                                             : ~(q & {WIDTH{oe[b]}});
    end

    // Single state machine. Priority at each edge: reset, word load,
    // sequence (re)start, byte write, increment. err and done are pulses,
    // so they default low every cycle and are raised only when triggered.
    always_ff @(posedge clk) begin
        if (reset) begin
            q     <= '0;
            state <= IDLE;
            k     <= '0;
            done  <= 1'b0;
            carry <= 1'b0;
            err   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            if (wide_ld) begin
                // Word load aborts any sequence; an aborted sequence or an
                // increment that loses to the load is flagged.
                q     <= wide_d;
                state <= IDLE;
                k     <= '0;
                err   <= (state == SEQ) || inc;
            end else if (seq_start) begin
                // Restarting a running sequence discards the byte presented
                // this cycle and flags the override.
                state <= SEQ;
                k     <= '0;
                err   <= (state == SEQ) || inc;
            end else if (state == SEQ) begin
                // Increments cannot be honoured mid-sequence.
                err <= inc;
                if (din_valid) begin
                    for (int b = 0; b < BYTES; b++) begin
                        if (k == KW'(b)) begin
                            q[b*8 +: 8] <= din;
                        end
                    end
                    if (k == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        k     <= '0;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
            end else begin
                // IDLE or DONE: DONE always falls back to IDLE after its
                // single cycle; increments are accepted in either state.
                state <= IDLE;
                if (inc) begin
                    q     <= q + WIDTH'(1);
                    carry <= &q;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm83_reg_wz_bank.sv
// ---------------------------------------------------------------------------
// tb_sm83_reg_wz_bank
//
// Directed bench for sm83_reg_wz_bank with WIDTH=16, NBUS=2. Expected values
// are queued when the stimulus is driven and drained against the outputs
// after the following clock edge (or after a short settle for combinational
// outputs).
// ---------------------------------------------------------------------------
module tb_sm83_reg_wz_bank;

    localparam int WIDTH = 16;
    localparam int NBUS  = 2;

    typedef enum int {K_Q, K_BUSY, K_DONE, K_CARRY, K_ERR, K_READY, K_BUS, K_MUX} kind_t;

    typedef struct {
        string       tag;
        kind_t       kind;
        logic [31:0] exp;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pch;
    logic [7:0]            din;
    logic                  din_valid;
    logic                  din_ready;
    logic                  seq_start;
    logic                  wide_ld;
    logic [WIDTH-1:0]      wide_d;
    logic                  inc;
    logic [NBUS-1:0]       oe;
    logic                  mux_sel;
    logic [WIDTH-1:0]      mux_alt;
    logic [WIDTH-1:0]      q;
    logic [NBUS*WIDTH-1:0] bus_y;
    logic [WIDTH-1:0]      mux_y;
    logic                  busy;
    logic                  done;
    logic                  carry;
    logic                  err;

    exp_t scoreboard[$];
    int   testCount = 0;
    int   failCount = 0;

    sm83_reg_wz_bank #(.WIDTH(WIDTH), .NBUS(NBUS)) dut (
        .clk       (clk),
        .reset     (reset),
        .pch       (pch),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .seq_start (seq_start),
        .wide_ld   (wide_ld),
        .wide_d    (wide_d),
        .inc       (inc),
        .oe        (oe),
        .mux_sel   (mux_sel),
        .mux_alt   (mux_alt),
        .q         (q),
        .bus_y     (bus_y),
        .mux_y     (mux_y),
        .busy      (busy),
        .done      (done),
        .carry     (carry),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Drives the sequential-control inputs for the next edge.
    task automatic applyStimulus(input logic s, input logic w, input logic [15:0] wd,
                                 input logic dv, input logic [7:0] d, input logic i);
        seq_start = s;
        wide_ld   = w;
        wide_d    = wd;
        din_valid = dv;
        din       = d;
        inc       = i;
    endtask

    task automatic expect_val(input string tag, input kind_t kind, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        scoreboard.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] observe(input kind_t kind);
        case (kind)
            K_Q:     return {16'h0, q};
            K_BUSY:  return {31'h0, busy};
            K_DONE:  return {31'h0, done};
            K_CARRY: return {31'h0, carry};
            K_ERR:   return {31'h0, err};
            K_READY: return {31'h0, din_ready};
            K_BUS:   return bus_y;
            default: return {16'h0, mux_y};
        endcase
    endfunction

    // Drains every queued expectation against the current outputs.
    task automatic checkOutput();
        exp_t        e;
        logic [31:0] obs;
        while (scoreboard.size() > 0) begin
            e   = scoreboard.pop_front();
            obs = observe(e.kind);
            testCount++;
            assert (obs === e.exp) else begin
                failCount++;
                $error("[TB] FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        pch     = 1'b1;
        oe      = 2'b00;
        mux_sel = 1'b0;
        mux_alt = 16'h0000;
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0);

        // Reset state
        @(negedge clk);
        expect_val("rst_q", K_Q, 32'h0);
        expect_val("rst_busy", K_BUSY, 32'h0);
        expect_val("rst_done", K_DONE, 32'h0);
        expect_val("rst_carry", K_CARRY, 32'h0);
        expect_val("rst_err", K_ERR, 32'h0);
        expect_val("rst_ready", K_READY, 32'h0);
        expect_val("rst_bus_pch", K_BUS, 32'hFFFF_FFFF);
        tick();
        checkOutput();
        reset = 1'b0;
        pch   = 1'b0;
        oe    = 2'b11;
        #1;
        expect_val("idle_bus_eval", K_BUS, 32'hFFFF_FFFF);
        checkOutput();

        // Back-to-back byte-serial load
        applyStimulus(1, 0, 16'h0, 0, 8'h0, 0);
        expect_val("s1_busy", K_BUSY, 32'h1);
        expect_val("s1_ready", K_READY, 32'h1);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 1, 8'h34, 0);
        expect_val("s1_lo_q", K_Q, 32'h0034);
        expect_val("s1_lo_busy", K_BUSY, 32'h1);
        expect_val("s1_lo_done", K_DONE, 32'h0);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 1, 8'h12, 0);
        expect_val("s1_hi_q", K_Q, 32'h1234);
        expect_val("s1_hi_busy", K_BUSY, 32'h0);
        expect_val("s1_hi_done", K_DONE, 32'h1);
        expect_val("s1_hi_ready", K_READY, 32'h0);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0);
        oe = 2'b01;
        #1;
        expect_val("s1_bus_oe01", K_BUS, 32'hFFFF_EDCB);
        checkOutput();
        expect_val("s1_done_clr", K_DONE, 32'h0);
        expect_val("s1_err", K_ERR, 32'h0);
        tick(); checkOutput();

        // Inverting mux
        mux_alt = 16'h00FF;
        mux_sel = 1'b1;
        #1;
        expect_val("mux_sel1", K_MUX, 32'hEDCB);
        checkOutput();
        mux_sel = 1'b0;
        #1;
        expect_val("mux_sel0", K_MUX, 32'hFF00);
        checkOutput();

        // Load with din_valid gaps
        applyStimulus(1, 0, 16'h0, 0, 8'h0, 0);
        expect_val("s2_busy", K_BUSY, 32'h1);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 1, 8'hAA, 0);
        expect_val("s2_lo_q", K_Q, 32'h12AA);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 0, 8'hFF, 0);
        for (int n = 0; n < 3; n++) begin
            expect_val("s2_gap_busy", K_BUSY, 32'h1);
            expect_val("s2_gap_q", K_Q, 32'h12AA);
            expect_val("s2_gap_done", K_DONE, 32'h0);
            tick(); checkOutput();
        end
        applyStimulus(0, 0, 16'h0, 1, 8'h55, 0);
        expect_val("s2_hi_q", K_Q, 32'h55AA);
        expect_val("s2_hi_done", K_DONE, 32'h1);
        expect_val("s2_hi_busy", K_BUSY, 32'h0);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 0);
        expect_val("s2_done_clr", K_DONE, 32'h0);
        tick(); checkOutput();

        // Word load aborting a sequence at k=1
        applyStimulus(1, 0, 16'h0, 0, 8'h0, 0);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 1, 8'h11, 0);
        expect_val("ab_lo_q", K_Q, 32'h5511);
        tick(); checkOutput();
        applyStimulus(0, 1, 16'hBEEF, 0, 8'h0, 0);
        expect_val("ab_q", K_Q, 32'hBEEF);
        expect_val("ab_busy", K_BUSY, 32'h0);
        expect_val("ab_err", K_ERR, 32'h1);
        expect_val("ab_done", K_DONE, 32'h0);
        tick(); checkOutput();
        // din_valid while idle must be ignored
        applyStimulus(0, 0, 16'h0, 1, 8'h77, 0);
        expect_val("idle_dv_q", K_Q, 32'hBEEF);
        expect_val("idle_dv_err", K_ERR, 32'h0);
        expect_val("idle_dv_done", K_DONE, 32'h0);
        expect_val("idle_dv_busy", K_BUSY, 32'h0);
        tick(); checkOutput();

        // Increment with carry
        applyStimulus(0, 1, 16'hFFFF, 0, 8'h0, 0);
        expect_val("inc_pre_q", K_Q, 32'hFFFF);
        expect_val("inc_pre_err", K_ERR, 32'h0);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1);
        expect_val("inc_wrap_q", K_Q, 32'h0000);
        expect_val("inc_wrap_carry", K_CARRY, 32'h1);
        tick(); checkOutput();
        expect_val("inc2_q", K_Q, 32'h0001);
        expect_val("inc2_carry", K_CARRY, 32'h0);
        tick(); checkOutput();
        applyStimulus(1, 0, 16'h0, 0, 8'h0, 0);
        expect_val("incseq_busy", K_BUSY, 32'h1);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 0, 8'h0, 1);
        expect_val("incseq_q", K_Q, 32'h0001);
        expect_val("incseq_err", K_ERR, 32'h1);
        expect_val("incseq_carry", K_CARRY, 32'h0);
        tick(); checkOutput();

        // Restart of a running sequence discards the concurrent byte
        applyStimulus(0, 0, 16'h0, 1, 8'h22, 0);
        expect_val("rs_lo_q", K_Q, 32'h0022);
        expect_val("rs_lo_err", K_ERR, 32'h0);
        tick(); checkOutput();
        applyStimulus(1, 0, 16'h0, 1, 8'h33, 0);
        expect_val("rs_q", K_Q, 32'h0022);
        expect_val("rs_err", K_ERR, 32'h1);
        expect_val("rs_busy", K_BUSY, 32'h1);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 1, 8'h44, 0);
        expect_val("rs_k0_q", K_Q, 32'h0044);
        expect_val("rs_k0_err", K_ERR, 32'h0);
        tick(); checkOutput();
        applyStimulus(0, 0, 16'h0, 1, 8'h66, 0);
        expect_val("rs_hi_q", K_Q, 32'h6644);
        expect_val("rs_hi_done", K_DONE, 32'h1);
        tick(); checkOutput();

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
